// File: rtl/pulse_rate_meter_pkg.sv
// Shared definitions for the pulse rate meter: FSM encodings and a counter sizing helper.
package pulse_rate_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } meter_state_t;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int unsigned bits_for(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 32'd1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pulse_rate_meter_edge_sync.sv
// Synchroniser for an asynchronous input followed by a one-cycle rising-edge detector.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;

    // Shift the raw input through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], sig_in};
            sync_d_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~sync_d_r;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts rising edges of sig_in over back-to-back gate windows of the board clock and publishes
// each window's count with a one-cycle valid strobe.
module pulse_rate_meter
    import pulse_rate_meter_pkg::*;
#(
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int GATE_FREQUENCY_IN_HZ        = 1,
    parameter int COUNT_WIDTH                 = 32,
    parameter int SYNC_STAGES                 = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   sig_in,
    output logic [COUNT_WIDTH-1:0] freq_out,
    output logic                   freq_valid,
    output logic                   overflow,
    output logic                   gate_tick
);

    localparam int unsigned GATE_COUNT = BOARD_CLOCK_FREQUENCY_IN_HZ / GATE_FREQUENCY_IN_HZ;
    localparam int unsigned GATE_W     = bits_for(GATE_COUNT);
    localparam int unsigned SETTLE_W   = bits_for(SYNC_STAGES + 1);
    localparam logic [GATE_W-1:0]      GATE_LAST   = GATE_W'(GATE_COUNT - 1);
    localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SYNC_STAGES);
    localparam logic [COUNT_WIDTH-1:0] EDGE_MAX    = {COUNT_WIDTH{1'b1}};

    meter_state_t           state_r, state_nxt;
    logic [SETTLE_W-1:0]    settle_r, settle_nxt;
    logic [GATE_W-1:0]      gate_r, gate_nxt;
    logic [COUNT_WIDTH-1:0] edges_r, edges_nxt, edges_inc_s;
    logic                   sat_r, sat_nxt, sat_inc_s;
    logic                   window_done_s;
    logic                   rise_s;

    logic [COUNT_WIDTH-1:0] freq_out_r;
    logic                   freq_valid_r;
    logic                   overflow_r;
    logic                   gate_tick_r;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .rise  (rise_s)
    );

    // Edge count including this cycle's rise; a rise at full scale only marks saturation.
    always_comb begin
        edges_inc_s = edges_r;
        sat_inc_s   = sat_r;
        if (rise_s) begin
            if (edges_r == EDGE_MAX) begin
                sat_inc_s = 1'b1;
            end else begin
                edges_inc_s = edges_r + COUNT_WIDTH'(1'b1);
            end
        end else begin
            edges_inc_s = edges_r;
        end
    end

    // Next-state logic; counters fall back to zero unless a state keeps them running.
    always_comb begin
        state_nxt     = state_r;
        settle_nxt    = {SETTLE_W{1'b0}};
        gate_nxt      = {GATE_W{1'b0}};
        edges_nxt     = {COUNT_WIDTH{1'b0}};
        sat_nxt       = 1'b0;
        window_done_s = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_r == SETTLE_LAST) begin
                        state_nxt = ST_MEASURE;
                    end else begin
                        settle_nxt = settle_r + SETTLE_W'(1'b1);
                    end
                end
                ST_MEASURE: begin
                    if (gate_r == GATE_LAST) begin
                        window_done_s = 1'b1;
                    end else begin
                        gate_nxt  = gate_r + GATE_W'(1'b1);
                        edges_nxt = edges_inc_s;
                        sat_nxt   = sat_inc_s;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // FSM and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            settle_r <= {SETTLE_W{1'b0}};
            gate_r   <= {GATE_W{1'b0}};
            edges_r  <= {COUNT_WIDTH{1'b0}};
            sat_r    <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            settle_r <= settle_nxt;
            gate_r   <= gate_nxt;
            edges_r  <= edges_nxt;
            sat_r    <= sat_nxt;
        end
    end

    // Output registers; gate_tick is registered from the next-cycle gate value so it lines up
    // with the final window cycle, and the result lands on the following (restart) cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_out_r   <= {COUNT_WIDTH{1'b0}};
            overflow_r   <= 1'b0;
            freq_valid_r <= 1'b0;
            gate_tick_r  <= 1'b0;
        end else begin
            freq_valid_r <= window_done_s;
            gate_tick_r  <= (state_nxt == ST_MEASURE) && (gate_nxt == GATE_LAST);
            if (window_done_s) begin
                freq_out_r <= edges_inc_s;
                overflow_r <= sat_inc_s;
            end else begin
                freq_out_r <= freq_out_r;
                overflow_r <= overflow_r;
            end
        end
    end

    assign freq_out   = freq_out_r;
    assign freq_valid = freq_valid_r;
    assign overflow   = overflow_r;
    assign gate_tick  = gate_tick_r;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Directed bench for pulse_rate_meter: an 8-bit and a 4-bit counter instance share all inputs.
module tb_pulse_rate_meter;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       sig_in;
    logic       gen_on;
    logic       gen_sig;
    logic       man_sig;
    int         half;
    int         gen_cnt;

    logic [7:0] freq_out_a;
    logic       freq_valid_a, overflow_a, gate_tick_a;
    logic [3:0] freq_out_b;
    logic       freq_valid_b, overflow_b, gate_tick_b;

    int checks = 0;
    int errors = 0;

    assign sig_in = gen_on ? gen_sig : man_sig;

    pulse_rate_meter #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .GATE_FREQUENCY_IN_HZ       (10),
        .COUNT_WIDTH                (8),
        .SYNC_STAGES                (2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .freq_out  (freq_out_a),
        .freq_valid(freq_valid_a),
        .overflow  (overflow_a),
        .gate_tick (gate_tick_a)
    );

    pulse_rate_meter #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
        .GATE_FREQUENCY_IN_HZ       (10),
        .COUNT_WIDTH                (4),
        .SYNC_STAGES                (2)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .freq_out  (freq_out_b),
        .freq_valid(freq_valid_b),
        .overflow  (overflow_b),
        .gate_tick (gate_tick_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave source: each level lasts 'half' clock cycles.
    initial begin
        gen_sig = 1'b0;
        gen_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            gen_cnt++;
            if (gen_cnt >= half) begin
                gen_sig = ~gen_sig;
                gen_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next freq_valid of the 8-bit instance; n = cycles taken.
    task automatic wait_valid(input string tag, input int budget, output int n);
        logic prev_tick;
        bit   seen;
        n         = 0;
        seen      = 1'b0;
        prev_tick = 1'b0;
        while (!seen && n < budget) begin
            prev_tick = gate_tick_a;
            tick();
            n++;
            if (freq_valid_a) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_tick_before_valid"}, 32'(prev_tick), 32'd1);
            check({tag, "_no_tick_with_valid"}, 32'(gate_tick_a), 32'd0);
            check({tag, "_valid_b_aligned"}, 32'(freq_valid_b), 32'd1);
        end
    endtask

    task automatic wait_tick(input string tag, input int budget);
        int n;
        n = 0;
        while (!gate_tick_a && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_tick_seen"}, 32'(gate_tick_a), 32'd1);
    endtask

    initial begin
        int n;
        int cnt;
        int v;

        rst     = 1'b0;
        enable  = 1'b0;
        gen_on  = 1'b1;
        man_sig = 1'b0;
        half    = 5;

        // 1: reset and idle behaviour.
        repeat (3) tick();
        check("rst_freq_out_a", 32'(freq_out_a), 32'd0);
        check("rst_valid_a", 32'(freq_valid_a), 32'd0);
        check("rst_overflow_a", 32'(overflow_a), 32'd0);
        check("rst_gate_tick_a", 32'(gate_tick_a), 32'd0);
        check("rst_freq_out_b", 32'(freq_out_b), 32'd0);
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (freq_valid_a || freq_valid_b || gate_tick_a || gate_tick_b) cnt++;
        end
        check("idle_no_activity", 32'(cnt), 32'd0);

        // 2: period 10 -> 10 edges per window, windows 100 cycles apart.
        enable = 1'b1;
        wait_valid("p10_first", 300, n);
        check("p10_first_count", 32'(freq_out_a), 32'd10);
        check("p10_first_ovf", 32'(overflow_a), 32'd0);
        for (int w = 0; w < 2; w++) begin
            wait_valid("p10", 200, n);
            check("p10_interval", 32'(n), 32'd100);
            check("p10_count_a", 32'(freq_out_a), 32'd10);
            check("p10_ovf_a", 32'(overflow_a), 32'd0);
            check("p10_count_b", 32'(freq_out_b), 32'd10);
            check("p10_ovf_b", 32'(overflow_b), 32'd0);
        end

        // 3/4: period 4 -> 25 edges; the 4-bit instance saturates at 15.
        half = 2;
        wait_valid("p4_transition", 200, n);
        wait_valid("p4", 200, n);
        check("p4_count_a", 32'(freq_out_a), 32'd25);
        check("p4_ovf_a", 32'(overflow_a), 32'd0);
        check("p4_count_b", 32'(freq_out_b), 32'd15);
        check("p4_ovf_b", 32'(overflow_b), 32'd1);
        repeat (50) tick();
        half = 10;
        wait_valid("p20_mixed", 200, n);
        v = int'(freq_out_a);
        check("p20_mixed_in_range", 32'((v >= 5) && (v <= 25)), 32'd1);
        wait_valid("p20", 200, n);
        check("p20_count_a", 32'(freq_out_a), 32'd5);
        check("p20_count_b", 32'(freq_out_b), 32'd5);
        check("p20_ovf_b_cleared", 32'(overflow_b), 32'd0);

        // 5: rises placed on the final cycle and on the restart cycle of a window.
        gen_on  = 1'b0;
        man_sig = 1'b0;
        wait_valid("man_flush", 200, n);
        wait_tick("man_t0", 200);
        repeat (98) tick();
        man_sig = 1'b1;
        repeat (2) tick();
        check("final_cycle_tick", 32'(gate_tick_a), 32'd1);
        tick();
        check("final_cycle_valid", 32'(freq_valid_a), 32'd1);
        check("final_cycle_rise_counted", 32'(freq_out_a), 32'd1);
        repeat (19) tick();
        man_sig = 1'b0;
        repeat (79) tick();
        man_sig = 1'b1;
        tick();
        check("restart_prev_tick", 32'(gate_tick_a), 32'd1);
        tick();
        check("restart_prev_valid", 32'(freq_valid_a), 32'd1);
        check("restart_prev_count", 32'(freq_out_a), 32'd0);
        repeat (99) tick();
        check("restart_new_tick", 32'(gate_tick_a), 32'd1);
        tick();
        check("restart_new_valid", 32'(freq_valid_a), 32'd1);
        check("restart_rise_in_new_window", 32'(freq_out_a), 32'd1);

        // 6: enable dropped mid-window, then reset mid-window.
        gen_on = 1'b1;
        half   = 5;
        wait_valid("p10b_transition", 200, n);
        wait_valid("p10b", 200, n);
        check("p10b_count", 32'(freq_out_a), 32'd10);
        repeat (50) tick();
        enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (freq_valid_a) cnt++;
        end
        check("disable_no_valid", 32'(cnt), 32'd0);
        check("disable_holds_freq", 32'(freq_out_a), 32'd10);
        enable = 1'b1;
        // One cycle to leave IDLE, three SETTLE cycles, then the 100-cycle window.
        wait_valid("reenable", 300, n);
        check("reenable_latency", 32'(n), 32'd104);
        check("reenable_count", 32'(freq_out_a), 32'd10);
        repeat (50) tick();
        rst = 1'b0;
        tick();
        check("midrst_freq_out", 32'(freq_out_a), 32'd0);
        check("midrst_valid", 32'(freq_valid_a), 32'd0);
        check("midrst_overflow", 32'(overflow_a), 32'd0);
        tick();
        rst = 1'b1;
        wait_valid("post_rst", 300, n);
        check("post_rst_latency", 32'(n), 32'd104);
        check("post_rst_count", 32'(freq_out_a), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
